axi_ram_responder: RTL and testbench
====================================

# axi_ram_responder

AXI4 responder (slave) that terminates the burst traffic issued by the L2 cache's AXI master port and serves it from an internal byte-enabled single-port RAM. It replaces the DDR controller in simulation and on-chip-memory builds. Single read or write burst in flight, INCR bursts of full bus width, read/write arbitration by alternation.

## Interface
- ADDR_W, 30: AXI byte address width (matches DDR address width).
- DATA_W, 256: AXI data width (matches MIG bus width); power of two, ≥32.
- MEM_ADDR_W, 14: RAM depth in DATA_W words, log2.
- ID_W, 1: AXI ID width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- axi_awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/ADDR_W/8/3/2/1  write address.
- axi_awready  out  1.
- axi_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data.
- axi_wready  out  1.
- axi_bid/bresp/bvalid  out  ID_W/2/1  write response.
- axi_bready  in  1.
- axi_arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/8/3/2/1  read address.
- axi_arready  out  1.
- axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1  read data.
- axi_rready  in  1.
- Lock/cache/prot/qos inputs accepted and ignored.

## Operation
- Word index = addr[MEM_ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)]; low byte-offset bits ignored; size/burst fields ignored, every burst treated as INCR of full-width beats, awlen+1 beats.
- FSM: IDLE, WR_DATA, WR_RESP, RD_DATA.
- IDLE: awready/arready asserted only for the selected channel. Only one valid → that one wins. Both valid → channel opposite to the last served wins (reset: last = read, so write wins first). Handshake latches id, word index, len; beat counter cleared.
- WR_DATA: wready=1. Each wvalid&wready writes wdata under wstrb to RAM[index], index+1, counter+1. Burst ends on beat len (counter==len) regardless of wlast; error flag set if wlast differs from (counter==len) on any beat. → WR_RESP.
- WR_RESP: bvalid=1, bid=latched id, bresp=OKAY (2'b00) or SLVERR (2'b10) if error flag. bvalid&bready → IDLE.
- RD_DATA: one-entry output register plus RAM read pipeline; RAM read issued whenever output register empty or being consumed this cycle and beats remain. rid=latched id, rresp=OKAY, rlast on beat len. rvalid&rready&rlast → IDLE.
- Index wraps modulo 2^MEM_ADDR_W when the burst crosses the RAM top.
- Outputs stable while valid and not ready (AXI rule); rdata/rlast/rid never change under rvalid&!rready.

## Timing
- Reset (rst low, async): state IDLE, all *valid and *ready low, bresp/rresp 0, bid/rid 0, rdata 0, rlast 0, last=read. Mid-burst reset aborts burst; RAM contents untouched.
- awready/arready combinational from state and valids in IDLE; address handshake cycle N → wready high N+1.
- Write: one beat per cycle; bvalid cycle after last beat accepted.
- Read: ar handshake N → first rvalid N+2; with rready held high, one beat per cycle, last beat at N+2+len.
- Back-to-back: IDLE re-entered cycle after B or last R handshake; next address accepted that cycle.
- Read-after-write to same word returns written data (write completes before B).

## Configuration
- AXI_RAM_DECERR_EN defined: address decoding checks bits above RAM range; any beat whose full word address ≥ 2^MEM_ADDR_W is suppressed (no RAM write, rdata 0) and sets bresp/rresp DECERR (2'b11), per beat for R, sticky for B; no wrap.
- Undefined: upper bits ignored, wrap-around as in Operation, DECERR never produced.

## Structure
- Shared header axi_ram.vh: FSM state encodings, AXI response codes (OKAY, SLVERR, DECERR), byte-offset width function.
- One sub-module: axi_ram_sp_be — single-port RAM, DATA_W/8 byte enables, 1-cycle synchronous read, shared between write and read paths (mutually exclusive by FSM).

## Test plan
- Write burst awaddr 0x100, awlen 15, data k*0x11, all strobes → 16 beats accepted at one per cycle, bresp 0, bid matches; read-back 0x100 len 15 returns same data, rlast on beat 16, first rvalid 2 cycles after ar.
- Partial strobe: write 0xFF..FF then wstrb 0x1 with 0x00 at same word → read returns 0xFF..F00.
- Simultaneous awvalid and arvalid from reset → write served first, then read; repeat → alternates.
- Random rready deassertion during 16-beat read → no beat lost/duplicated, data stable while stalled.
- wlast asserted on beat 3 of awlen 7 → all 8 beats still written, bresp 2'b10.
- Burst starting at last RAM word, awlen 1 → macro off: second beat writes word 0, OKAY; macro on: second beat suppressed, bresp 2'b11.

Source files
------------

// File: rtl/axi_ram_responder_pkg.sv
// Shared definitions for the AXI RAM responder.
// - state_e    : responder FSM states
// - Resp*      : AXI response codes
// - byte_off_w : number of byte-offset address bits for a given data width
package axi_ram_responder_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWrData,
        StWrResp,
        StRdData
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    function automatic int unsigned byte_off_w(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/axi_ram_sp_be.sv
// Single-port RAM with per-byte write enables and a 1-cycle synchronous read.
// The read register holds its value while en_i is low, so a fetched word can
// wait there until the consumer is ready.
// Ports:
//   clk_i   : clock
//   en_i    : access enable
//   we_i    : write (1) or read (0) when enabled
//   be_i    : byte enables for writes
//   addr_i  : word address
//   wdata_i : write data
//   rdata_o : registered read data
module axi_ram_sp_be #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 14
) (
    input  logic                clk_i,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < int'(DATA_W / 8); b++) begin
                    if (be_i[b]) begin
                        mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end else begin
                rdata_o <= mem[addr_i];
            end
        end
    end

endmodule

// File: rtl/axi_ram_responder.sv
// AXI4 responder serving one read or write INCR burst at a time from an
// internal byte-enabled RAM. Read/write arbitration alternates when both
// address channels are valid (write first after reset).
// Optional feature: define AXI_RAM_DECERR_EN to decode the address bits above
// the RAM range; beats falling outside are suppressed and answered DECERR.
// Without it those bits are ignored and bursts wrap at the RAM top.
// Ports:
//   clk, rst (async, active-low)
//   axi_aw* / axi_w* / axi_b* : write address, data, response channels
//   axi_ar* / axi_r*          : read address and data channels
//   lock/cache/prot/qos and size/burst inputs are accepted and ignored
module axi_ram_responder
    import axi_ram_responder_pkg::*;
#(
    parameter int unsigned ADDR_W     = 30,
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned MEM_ADDR_W = 14,
    parameter int unsigned ID_W       = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ID_W-1:0]     axi_awid,
    input  logic [ADDR_W-1:0]   axi_awaddr,
    input  logic [7:0]          axi_awlen,
    input  logic [2:0]          axi_awsize,
    input  logic [1:0]          axi_awburst,
    input  logic                axi_awlock,
    input  logic [3:0]          axi_awcache,
    input  logic [2:0]          axi_awprot,
    input  logic [3:0]          axi_awqos,
    input  logic                axi_awvalid,
    output logic                axi_awready,
    input  logic [DATA_W-1:0]   axi_wdata,
    input  logic [DATA_W/8-1:0] axi_wstrb,
    input  logic                axi_wlast,
    input  logic                axi_wvalid,
    output logic                axi_wready,
    output logic [ID_W-1:0]     axi_bid,
    output logic [1:0]          axi_bresp,
    output logic                axi_bvalid,
    input  logic                axi_bready,
    input  logic [ID_W-1:0]     axi_arid,
    input  logic [ADDR_W-1:0]   axi_araddr,
    input  logic [7:0]          axi_arlen,
    input  logic [2:0]          axi_arsize,
    input  logic [1:0]          axi_arburst,
    input  logic                axi_arlock,
    input  logic [3:0]          axi_arcache,
    input  logic [2:0]          axi_arprot,
    input  logic [3:0]          axi_arqos,
    input  logic                axi_arvalid,
    output logic                axi_arready,
    output logic [ID_W-1:0]     axi_rid,
    output logic [DATA_W-1:0]   axi_rdata,
    output logic [1:0]          axi_rresp,
    output logic                axi_rlast,
    output logic                axi_rvalid,
    input  logic                axi_rready
);

    localparam int unsigned OFF_W = byte_off_w(DATA_W);
`ifdef AXI_RAM_DECERR_EN
    // Keep the full word address so out-of-range beats can be detected.
    localparam int unsigned IDX_W = ADDR_W - OFF_W;
`else
    localparam int unsigned IDX_W = MEM_ADDR_W;
`endif

    state_e state_q, state_d;

    logic                  last_rd_q;
    logic [ID_W-1:0]       id_q;
    logic [IDX_W-1:0]      idx_q;
    logic [7:0]            len_q;
    logic [8:0]            cnt_q;
    logic                  slverr_q, decerr_q;
    logic                  rd_pend_q, pend_last_q, pend_oob_q;
    logic                  rvalid_q, rlast_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [1:0]            rresp_q;

    logic [IDX_W-1:0]      aw_idx, ar_idx;
    logic                  ar_oob, cur_oob;
    logic                  aw_sel, ar_sel, aw_hs, ar_hs, w_hs, b_hs, r_fire;
    logic                  at_len, beats_left, out_free, rd_issue, rd_load;
    logic                  ram_en, ram_we;
    logic [MEM_ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0]     ram_rdata;
    logic                  unused_ign;

    assign aw_idx = axi_awaddr[OFF_W +: IDX_W];
    assign ar_idx = axi_araddr[OFF_W +: IDX_W];

`ifdef AXI_RAM_DECERR_EN
    assign ar_oob  = |ar_idx[IDX_W-1:MEM_ADDR_W];
    assign cur_oob = |idx_q[IDX_W-1:MEM_ADDR_W];
`else
    assign ar_oob  = 1'b0;
    assign cur_oob = 1'b0;
`endif

    assign unused_ign = ^{axi_awaddr, axi_araddr, axi_awsize, axi_awburst, axi_arsize,
                          axi_arburst, axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                          axi_arlock, axi_arcache, axi_arprot, axi_arqos};

    // Write wins on a tie unless the last served burst was a write.
    assign aw_sel = axi_awvalid & (~axi_arvalid | last_rd_q);
    assign ar_sel = axi_arvalid & ~aw_sel;

    assign aw_hs      = (state_q == StIdle) & aw_sel;
    assign ar_hs      = (state_q == StIdle) & ar_sel;
    assign w_hs       = (state_q == StWrData) & axi_wvalid;
    assign b_hs       = (state_q == StWrResp) & axi_bready;
    assign r_fire     = rvalid_q & axi_rready;
    assign at_len     = (cnt_q == {1'b0, len_q});
    assign beats_left = (cnt_q <= {1'b0, len_q});
    assign out_free   = ~rvalid_q | axi_rready;

    // The first read is issued in the ar handshake cycle itself; later reads only
    // when the output register will have room for the word arriving next cycle.
    assign rd_issue = ar_hs | ((state_q == StRdData) & out_free & beats_left);
    assign rd_load  = rd_pend_q & out_free;

    assign ram_we   = w_hs & ~cur_oob;
    assign ram_en   = ram_we | rd_issue;
    assign ram_addr = ar_hs ? ar_idx[MEM_ADDR_W-1:0] : idx_q[MEM_ADDR_W-1:0];

    axi_ram_sp_be #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (axi_wstrb),
        .addr_i  (ram_addr),
        .wdata_i (axi_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (aw_hs) begin
                    state_d = StWrData;
                end else if (ar_hs) begin
                    state_d = StRdData;
                end
            end
            StWrData: if (w_hs && at_len) state_d = StWrResp;
            StWrResp: if (b_hs) state_d = StIdle;
            StRdData: if (r_fire && rlast_q) state_d = StIdle;
        endcase
    end

    always_comb begin
        axi_awready = aw_hs;
        axi_arready = ar_hs;
        axi_wready  = (state_q == StWrData);
        axi_bvalid  = (state_q == StWrResp);
        axi_bresp   = decerr_q ? RespDecerr : (slverr_q ? RespSlverr : RespOkay);
        axi_bid     = id_q;
        axi_rid     = id_q;
        axi_rvalid  = rvalid_q;
        axi_rdata   = rdata_q;
        axi_rresp   = rresp_q;
        axi_rlast   = rlast_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_rd_q   <= 1'b1;
            id_q        <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            slverr_q    <= 1'b0;
            decerr_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            pend_last_q <= 1'b0;
            pend_oob_q  <= 1'b0;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= RespOkay;
        end else begin
            if (aw_hs) begin
                last_rd_q <= 1'b0;
                id_q      <= axi_awid;
                idx_q     <= aw_idx;
                len_q     <= axi_awlen;
                cnt_q     <= '0;
                slverr_q  <= 1'b0;
                decerr_q  <= 1'b0;
            end else if (ar_hs) begin
                last_rd_q <= 1'b1;
                id_q      <= axi_arid;
                idx_q     <= ar_idx + IDX_W'(1);
                len_q     <= axi_arlen;
                cnt_q     <= 9'd1;
            end else if (w_hs) begin
                idx_q <= idx_q + IDX_W'(1);
                cnt_q <= cnt_q + 9'd1;
                // Burst length comes from awlen; a misplaced wlast is only reported.
                if (axi_wlast != at_len) slverr_q <= 1'b1;
                if (cur_oob) decerr_q <= 1'b1;
            end else if (rd_issue) begin
                idx_q <= idx_q + IDX_W'(1);
                cnt_q <= cnt_q + 9'd1;
            end

            if (rd_issue) begin
                rd_pend_q   <= 1'b1;
                pend_last_q <= ar_hs ? (axi_arlen == 8'd0) : at_len;
                pend_oob_q  <= ar_hs ? ar_oob : cur_oob;
            end else if (rd_load) begin
                rd_pend_q <= 1'b0;
            end

            if (rd_load) begin
                rvalid_q <= 1'b1;
                rlast_q  <= pend_last_q;
                rdata_q  <= pend_oob_q ? '0 : ram_rdata;
                rresp_q  <= pend_oob_q ? RespDecerr : RespOkay;
            end else if (r_fire) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_ram_responder.sv
module tb_axi_ram_responder;

    localparam int ADDR_W     = 30;
    localparam int DATA_W     = 256;
    localparam int MEM_ADDR_W = 14;
    localparam int ID_W       = 1;
    localparam int STRB_W     = DATA_W / 8;
    localparam int DEPTH      = 1 << MEM_ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [STRB_W-1:0] strb_t;
    typedef struct {
        data_t      data;
        logic [1:0] resp;
    } rexp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [ID_W-1:0]   axi_awid = '0;
    logic [ADDR_W-1:0] axi_awaddr = '0;
    logic [7:0]        axi_awlen = '0;
    logic              axi_awvalid = 1'b0;
    logic              axi_awready;
    data_t             axi_wdata = '0;
    strb_t             axi_wstrb = '0;
    logic              axi_wlast = 1'b0;
    logic              axi_wvalid = 1'b0;
    logic              axi_wready;
    logic [ID_W-1:0]   axi_bid;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready = 1'b0;
    logic [ID_W-1:0]   axi_arid = '0;
    logic [ADDR_W-1:0] axi_araddr = '0;
    logic [7:0]        axi_arlen = '0;
    logic              axi_arvalid = 1'b0;
    logic              axi_arready;
    logic [ID_W-1:0]   axi_rid;
    data_t             axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;
    logic              axi_rvalid;
    logic              axi_rready = 1'b0;

    int checks = 0;
    int errors = 0;

    rexp_t exp_q[$];
    data_t model_mem[int];
    data_t wd_q[$];
    strb_t ws_q[$];
    bit    wl_q[$];

    always #5 clk = ~clk;

    axi_ram_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .ID_W       (ID_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .axi_awid    (axi_awid),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awsize  (3'd5),
        .axi_awburst (2'b01),
        .axi_awlock  (1'b0),
        .axi_awcache (4'd0),
        .axi_awprot  (3'd0),
        .axi_awqos   (4'd0),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wstrb   (axi_wstrb),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bid     (axi_bid),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready),
        .axi_arid    (axi_arid),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arsize  (3'd5),
        .axi_arburst (2'b01),
        .axi_arlock  (1'b0),
        .axi_arcache (4'd0),
        .axi_arprot  (3'd0),
        .axi_arqos   (4'd0),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rid     (axi_rid),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready)
    );

    // ---------------- reference model ----------------
    function automatic bit oob(input int word);
`ifdef AXI_RAM_DECERR_EN
        return word >= DEPTH;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int widx(input int word);
        return oob(word) ? word : word % DEPTH;
    endfunction

    function automatic void model_write(input int word, input data_t d, input strb_t s);
        data_t cur;
        if (oob(word)) return;
        cur = model_mem.exists(widx(word)) ? model_mem[widx(word)] : '0;
        for (int b = 0; b < STRB_W; b++) if (s[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        model_mem[widx(word)] = cur;
    endfunction

    function automatic void push_read(input int word, input int len);
        rexp_t e;
        for (int k = 0; k <= len; k++) begin
            if (oob(word + k)) begin
                e.data = '0;
                e.resp = 2'b11;
            end else begin
                e.data = model_mem.exists(widx(word + k)) ? model_mem[widx(word + k)] : '0;
                e.resp = 2'b00;
            end
            exp_q.push_back(e);
        end
    endfunction

    function automatic data_t rnd_data();
        data_t d;
        for (int j = 0; j < DATA_W / 32; j++) d[j*32 +: 32] = $urandom();
        return d;
    endfunction

    // ---------------- channel drivers ----------------
    task automatic do_aw(input int word, input int len, input logic [ID_W-1:0] id);
        int n = 0;
        axi_awvalid = 1'b1;
        axi_awaddr  = ADDR_W'(word * STRB_W);
        axi_awlen   = 8'(len);
        axi_awid    = id;
        #1;
        while (!axi_awready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (axi_awready !== 1'b1) begin
            errors++;
            $display("FAIL aw_handshake: awready=%b required 1", axi_awready);
        end
        @(negedge clk);
        axi_awvalid = 1'b0;
    endtask

    task automatic do_ar(input int word, input int len, input logic [ID_W-1:0] id);
        int n = 0;
        axi_arvalid = 1'b1;
        axi_araddr  = ADDR_W'(word * STRB_W);
        axi_arlen   = 8'(len);
        axi_arid    = id;
        #1;
        while (!axi_arready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (axi_arready !== 1'b1) begin
            errors++;
            $display("FAIL ar_handshake: arready=%b required 1", axi_arready);
        end
        @(negedge clk);
        axi_arvalid = 1'b0;
    endtask

    // Sends wd_q/ws_q/wl_q as beats starting at the current negedge.
    task automatic do_w(input int word);
        int stalls = 0;
        for (int k = 0; k < wd_q.size(); k++) begin
            axi_wvalid = 1'b1;
            axi_wdata  = wd_q[k];
            axi_wstrb  = ws_q[k];
            axi_wlast  = wl_q[k];
            #1;
            while (!axi_wready && stalls < 100) begin
                @(negedge clk);
                #1;
                stalls++;
            end
            model_write(word + k, wd_q[k], ws_q[k]);
            @(negedge clk);
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL w_rate: stall cycles=%0d required 0", stalls);
        end
    endtask

    task automatic do_b(input logic [ID_W-1:0] id, input logic [1:0] resp);
        int n = 0;
        axi_bready = 1'b1;
        #1;
        checks++;
        if (axi_bvalid !== 1'b1) begin
            errors++;
            $display("FAIL b_timing: bvalid=%b required 1 right after last beat", axi_bvalid);
        end
        while (!axi_bvalid && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (axi_bresp !== resp || axi_bid !== id) begin
            errors++;
            $display("FAIL b_resp: bresp=%b bid=%h required bresp=%b bid=%h",
                     axi_bresp, axi_bid, resp, id);
        end
        @(negedge clk);
        axi_bready = 1'b0;
    endtask

    // Collects n beats, checking each against the scoreboard head.
    task automatic do_r(input int n, input logic [ID_W-1:0] id, input bit stall,
                        input bit chk_lat);
        int    beat = 0, cyc = 0, first = -1, last_cyc = -1;
        bit    held_v = 0;
        data_t held_d;
        logic  held_l;
        rexp_t e;
        while (beat < n && cyc < 500) begin
            axi_rready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            if (held_v) begin
                checks++;
                if (axi_rvalid !== 1'b1 || axi_rdata !== held_d || axi_rlast !== held_l) begin
                    errors++;
                    $display("FAIL r_stable: rvalid=%b rlast=%b rdata=%h required 1 %b %h",
                             axi_rvalid, axi_rlast, axi_rdata, held_l, held_d);
                end
                held_v = 0;
            end
            if (axi_rvalid === 1'b1) begin
                if (first < 0) first = cyc;
                if (axi_rready) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (axi_rdata !== e.data || axi_rresp !== e.resp) begin
                        errors++;
                        $display("FAIL r_data beat %0d: rdata=%h rresp=%b required %h %b",
                                 beat, axi_rdata, axi_rresp, e.data, e.resp);
                    end
                    checks++;
                    if (axi_rlast !== (beat == n - 1) || axi_rid !== id) begin
                        errors++;
                        $display("FAIL r_last beat %0d: rlast=%b rid=%h required %b %h",
                                 beat, axi_rlast, axi_rid, (beat == n - 1), id);
                    end
                    beat++;
                    last_cyc = cyc;
                end else begin
                    held_v = 1;
                    held_d = axi_rdata;
                    held_l = axi_rlast;
                end
            end
            @(negedge clk);
            cyc++;
        end
        axi_rready = 1'b0;
        checks++;
        if (beat != n) begin
            errors++;
            $display("FAIL r_timeout: beats=%0d required %0d", beat, n);
            exp_q.delete();
        end
        if (chk_lat) begin
            checks++;
            if (first != 1 || last_cyc != n) begin
                errors++;
                $display("FAIL r_latency: first=%0d last=%0d required 1 %0d", first, last_cyc, n);
            end
        end
    endtask

    task automatic write_burst(input int word, input logic [ID_W-1:0] id,
                               input logic [1:0] resp);
        do_aw(word, wd_q.size() - 1, id);
        do_w(word);
        do_b(id, resp);
    endtask

    task automatic read_burst(input int word, input int len, input logic [ID_W-1:0] id,
                              input bit stall, input bit chk_lat);
        push_read(word, len);
        axi_rready = 1'b1;
        do_ar(word, len, id);
        do_r(len + 1, id, stall, chk_lat);
    endtask

    task automatic fill_w(input int n, input data_t d0, input bit rnd);
        wd_q.delete();
        ws_q.delete();
        wl_q.delete();
        for (int k = 0; k < n; k++) begin
            wd_q.push_back(rnd ? rnd_data() : d0);
            ws_q.push_back('1);
            wl_q.push_back(k == n - 1);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast,
             axi_bresp, axi_rresp, axi_bid, axi_rid} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: aw%b ar%b w%b b%b r%b last%b bresp%b rresp%b required 0",
                     axi_awready, axi_arready, axi_wready, axi_bvalid, axi_rvalid, axi_rlast,
                     axi_bresp, axi_rresp);
        end
        checks++;
        if (axi_rdata !== '0) begin
            errors++;
            $display("FAIL reset_rdata: rdata=%h required 0", axi_rdata);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst();
        wd_q.delete();
        ws_q.delete();
        wl_q.delete();
        for (int k = 0; k < 16; k++) begin
            wd_q.push_back(data_t'(k * 32'h11));
            ws_q.push_back('1);
            wl_q.push_back(k == 15);
        end
        write_burst('h100 / STRB_W, 1'b1, 2'b00);
        read_burst('h100 / STRB_W, 15, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_partial_strobe();
        int w = 'h2000 / STRB_W;
        fill_w(1, '1, 0);
        write_burst(w, 1'b0, 2'b00);
        fill_w(1, '0, 0);
        ws_q[0] = strb_t'(1);
        write_burst(w, 1'b0, 2'b00);
        read_burst(w, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_arbitration();
        test_reset();
        // Tie after reset: write goes first.
        axi_awvalid = 1'b1;
        axi_awaddr  = ADDR_W'('h6000);
        axi_awlen   = 8'd0;
        axi_awid    = 1'b1;
        axi_arvalid = 1'b1;
        axi_araddr  = ADDR_W'('h100);
        axi_arlen   = 8'd0;
        axi_arid    = 1'b0;
        #1;
        checks++;
        if (axi_awready !== 1'b1 || axi_arready !== 1'b0) begin
            errors++;
            $display("FAIL arb_first: awready=%b arready=%b required 1 0", axi_awready, axi_arready);
        end
        @(negedge clk);
        axi_awvalid = 1'b0;
        fill_w(1, data_t'(32'hCAFE), 0);
        do_w('h6000 / STRB_W);
        // Tie again while the response is pending: read should win next.
        axi_awvalid = 1'b1;
        axi_awaddr  = ADDR_W'('h6020);
        do_b(1'b1, 2'b00);
        #1;
        checks++;
        if (axi_arready !== 1'b1 || axi_awready !== 1'b0) begin
            errors++;
            $display("FAIL arb_alt_rd: awready=%b arready=%b required 0 1", axi_awready, axi_arready);
        end
        push_read('h100 / STRB_W, 0);
        @(negedge clk);
        axi_arvalid = 1'b0;
        do_r(1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (axi_awready !== 1'b1) begin
            errors++;
            $display("FAIL arb_alt_wr: awready=%b required 1", axi_awready);
        end
        @(negedge clk);
        axi_awvalid = 1'b0;
        fill_w(1, data_t'(32'hBEEF), 0);
        do_w('h6020 / STRB_W);
        do_b(1'b1, 2'b00);
        read_burst('h6000 / STRB_W, 1, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_rready_stall();
        fill_w(16, '0, 1);
        write_burst('h8000 / STRB_W, 1'b0, 2'b00);
        read_burst('h8000 / STRB_W, 15, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_wlast_error();
        fill_w(8, '0, 1);
        for (int k = 0; k < 8; k++) wl_q[k] = (k == 3);
        write_burst('hA000 / STRB_W, 1'b1, 2'b10);
        read_burst('hA000 / STRB_W, 7, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        fill_w(1, data_t'(32'hA5A5), 0);
        write_burst(0, 1'b0, 2'b00);
        fill_w(2, '0, 1);
`ifdef AXI_RAM_DECERR_EN
        write_burst(DEPTH - 1, 1'b0, 2'b11);
`else
        write_burst(DEPTH - 1, 1'b0, 2'b00);
`endif
        read_burst(DEPTH - 1, 1, 1'b0, 1'b0, 1'b0);
        read_burst(0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_midburst_reset();
        axi_rready = 1'b1;
        do_ar('h100 / STRB_W, 15, 1'b1);
        repeat (3) @(negedge clk);
        test_reset();
        axi_rready = 1'b0;
        exp_q.delete();
        read_burst('h100 / STRB_W, 3, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_partial_strobe();
        test_arbitration();
        test_rready_stall();
        test_wlast_error();
        test_wrap();
        test_midburst_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
